fifo_ctrl_unit: RTL and testbench
=================================

// Module: fifo_ctrl_unit
//
// PURPOSE
//   Pointer/flag controller for the SRAM-style FIFO. Sits directly upstream of the bank of
//   8-bit data registers and drives them:
//   - write strobe (wr_en) and write address (waddr) into the register bank;
//   - read address (raddr) into the read mux.
//   Tracks occupancy, full/empty, almost-full/almost-empty, and sticky overflow/underflow
//   error flags.
//
// PARAMETERS
//   ADDR_WIDTH  2   address bits; FIFO depth DEPTH = 2**ADDR_WIDTH
//   AF_LEVEL    3   almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL    1   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//
// PORTS
//   clk           input   1             clock, rising edge
//   rst           input   1             asynchronous reset, active-high
//   push          input   1             write request, data presented to register bank same cycle
//   pop           input   1             read request, consumes entry at raddr this cycle
//   clr_err       input   1             synchronous clear of overflow/underflow
//   wr_en         output  1             write strobe to register[waddr] (combinational)
//   waddr         output  ADDR_WIDTH    register index written on this edge
//   raddr         output  ADDR_WIDTH    register index of oldest entry (read mux select)
//   count         output  ADDR_WIDTH+1  entries held, 0..DEPTH
//   full          output  1             count == DEPTH
//   empty         output  1             count == 0
//   almost_full   output  1             count >= AF_LEVEL
//   almost_empty  output  1             count <= AE_LEVEL
//   overflow      output  1             sticky: push rejected since last clear
//   underflow     output  1             sticky: pop rejected since last clear
//
// BEHAVIOUR
//   - wr_ptr/rd_ptr are ADDR_WIDTH+1 bits; the MSB is the wrap bit.
//   - waddr = wr_ptr[ADDR_WIDTH-1:0]; raddr = rd_ptr[ADDR_WIDTH-1:0].
//   - full  = (addr bits equal) and (wrap bits differ).
//   - empty = (wr_ptr == rd_ptr).
//   - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1).
//   - Acceptance rules:
//       push_ok = push & (~full | pop)
//       pop_ok  = pop & ~empty
//     No bypass: pop while empty is rejected even if push is high.
//   - wr_en = push_ok & ~rst. The register bank captures data on the same edge that wr_ptr
//     increments: write latency is 1 clk.
//   - Read data is valid combinationally at raddr while ~empty. pop_ok advances rd_ptr on the
//     edge, so the next entry appears the following cycle.
//   - Pointers increment by 1 and wrap naturally: addr DEPTH-1 -> 0, with the wrap bit toggling.
//   - Simultaneous push_ok & pop_ok: both pointers advance and count is unchanged.
//     - When full, the write lands in the slot being read. Read data is sampled pre-edge, so no
//       corruption.
//   - All flags are derived combinationally from the registered pointers, so they update 1 clk
//     after the accepting edge.
//   - overflow  <= 1 on push & full & ~pop.
//   - underflow <= 1 on pop & empty.
//   - clr_err clears both error flags. If clr_err coincides with a new error event, the set wins.
//   - Rejected requests change no pointer and produce no wr_en.
//   - Reset (async, any time including mid-burst):
//       wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, almost_empty = 1,
//       almost_full = 0, overflow = underflow = 0, wr_en = 0, waddr = raddr = 0.
//     Stored register contents are irrelevant after reset; the FIFO is logically empty.
//
// TESTING
//   1. Reset, then push 4x (DEPTH=4).
//      -> wr_en high each cycle, waddr 0,1,2,3; count 4, full = 1, almost_full = 1 after
//         count reaches 3.
//   2. Full, push alone.
//      -> wr_en = 0, pointers unchanged, overflow = 1 next cycle.
//      Then pulse clr_err -> overflow = 0.
//   3. Full, push & pop together.
//      -> wr_en = 1, waddr == raddr == 0, count stays 4.
//      Popped entry is the old value; the new value reads out 4 pops later.
//   4. Empty, pop & push together.
//      -> pop rejected, underflow = 1, count = 1, empty = 0.
//   5. Push/pop 10 entries through depth 4.
//      -> waddr/raddr wrap 3->0 correctly, FIFO order is preserved, empty = 1 at end.
//   6. Assert rst mid-stream with count = 2.
//      -> all outputs return to reset values immediately (async).
//      Next push writes waddr 0.

Source files
------------

// File: rtl/fifo_ctrl_unit.sv
// fifo_ctrl_unit
//   Pointer/flag controller for an SRAM-style FIFO built from a bank of data
//   registers. Drives the write strobe/address into the bank and the read-mux
//   select, and reports occupancy plus sticky error flags.
//
//   Ports
//     clk, rst        clock (rising edge), asynchronous active-high reset
//     push, pop       write / read requests
//     clr_err         synchronous clear of overflow/underflow
//     wr_en, waddr    write strobe and index into the register bank
//     raddr           index of the oldest entry (read mux select)
//     count           entries held, 0..DEPTH
//     full, empty, almost_full, almost_empty   occupancy flags
//     overflow, underflow                      sticky rejected-request flags
module fifo_ctrl_unit #(
    parameter int ADDR_WIDTH = 2,
    parameter int AF_LEVEL   = 3,
    parameter int AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr_err,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    // MSB of each pointer is the wrap bit; it disambiguates full from empty.
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push_ok, pop_ok;

    assign waddr = wr_ptr[ADDR_WIDTH-1:0];
    assign raddr = rd_ptr[ADDR_WIDTH-1:0];

    assign full  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                   (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;

    assign almost_full  = (count >= AF_L);
    assign almost_empty = (count <= AE_L);

    // A push into a full FIFO is fine when a pop frees the slot on the same
    // edge. A pop on empty is never satisfied by a concurrent push.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    // Gate with rst so the bank never sees a strobe while pointers are held.
    assign wr_en = push_ok & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;

            // New error event beats a coincident clear.
            if (push & full & ~pop) overflow <= 1'b1;
            else if (clr_err)       overflow <= 1'b0;

            if (pop & empty)        underflow <= 1'b1;
            else if (clr_err)       underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_unit.sv
// Directed bench for fifo_ctrl_unit with a behavioural register bank.
module tb_fifo_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       push, pop, clr_err;
    logic       wr_en;
    logic [1:0] waddr, raddr;
    logic [2:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    logic [7:0] din;
    logic [7:0] mem [4];
    logic [7:0] rdata;

    int checks   = 0;
    int failures = 0;

    fifo_ctrl_unit #(.ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clr_err(clr_err),
        .wr_en(wr_en), .waddr(waddr), .raddr(raddr), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Register bank driven by the controller.
    always @(posedge clk) if (wr_en) mem[waddr] <= din;
    assign rdata = mem[raddr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge; checks follow 1ns later.
    task automatic drive(input logic p, input logic q, input logic c, input logic [7:0] d);
        @(negedge clk);
        push = p; pop = q; clr_err = c; din = d;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, 32'(count), 0);
        check({tag, "_empty"}, 32'(empty), 1);
        check({tag, "_full"},  32'(full), 0);
        check({tag, "_ae"},    32'(almost_empty), 1);
        check({tag, "_af"},    32'(almost_full), 0);
        check({tag, "_ovf"},   32'(overflow), 0);
        check({tag, "_unf"},   32'(underflow), 0);
        check({tag, "_wr_en"}, 32'(wr_en), 0);
        check({tag, "_waddr"}, 32'(waddr), 0);
        check({tag, "_raddr"}, 32'(raddr), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; push = 1'b1; pop = 1'b0; clr_err = 1'b0; din = 8'h00;
        #12;
        // push held high during reset must not strobe the bank
        check_reset_state("reset");
        push = 1'b0;
        @(negedge clk); rst = 1'b0;

        // 1: fill four entries
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 8'hA0 + 8'(i));
            check("fill_wr_en", 32'(wr_en), 1);
            check("fill_waddr", 32'(waddr), 32'(i));
            check("fill_count", 32'(count), 32'(i));
            check("fill_af",    32'(almost_full), 32'(i >= 3));
            check("fill_ae",    32'(almost_empty), 32'(i <= 1));
        end
        drive(0, 0, 0, 8'h00);
        check("full_count", 32'(count), 4);
        check("full_full",  32'(full), 1);
        check("full_af",    32'(almost_full), 1);
        check("full_ae",    32'(almost_empty), 0);
        check("full_empty", 32'(empty), 0);

        // 2: push into full alone
        drive(1, 0, 0, 8'hEE);
        check("ovf_wr_en",   32'(wr_en), 0);
        check("ovf_pre",     32'(overflow), 0);
        drive(0, 0, 0, 8'h00);
        check("ovf_set",     32'(overflow), 1);
        check("ovf_count",   32'(count), 4);
        check("ovf_waddr",   32'(waddr), 0);
        check("ovf_raddr",   32'(raddr), 0);
        check("ovf_rdata",   32'(rdata), 32'hA0);
        drive(0, 0, 1, 8'h00);
        check("clr_pre",     32'(overflow), 1);
        drive(0, 0, 0, 8'h00);
        check("clr_post",    32'(overflow), 0);

        // 3: full, push and pop together
        drive(1, 1, 0, 8'hB0);
        check("fpp_wr_en",   32'(wr_en), 1);
        check("fpp_waddr",   32'(waddr), 0);
        check("fpp_raddr",   32'(raddr), 0);
        check("fpp_rdata",   32'(rdata), 32'hA0);
        drive(0, 0, 0, 8'h00);
        check("fpp_count",   32'(count), 4);
        check("fpp_full",    32'(full), 1);
        check("fpp_ovf",     32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0, 8'h00);
            check("fpp_drain", 32'(rdata), (i < 3) ? 32'hA1 + 32'(i) : 32'hB0);
        end
        drive(0, 0, 0, 8'h00);
        check("drain_empty", 32'(empty), 1);
        check("drain_count", 32'(count), 0);
        check("drain_unf",   32'(underflow), 0);

        // 4: empty, push and pop together: pop rejected
        drive(1, 1, 0, 8'hC0);
        check("epp_wr_en",   32'(wr_en), 1);
        check("epp_waddr",   32'(waddr), 1);
        drive(0, 0, 0, 8'h00);
        check("epp_unf",     32'(underflow), 1);
        check("epp_count",   32'(count), 1);
        check("epp_empty",   32'(empty), 0);
        check("epp_rdata",   32'(rdata), 32'hC0);
        drive(0, 1, 1, 8'h00);   // valid pop with clear: clear applies
        drive(0, 0, 0, 8'h00);
        check("epp_clr",     32'(underflow), 0);
        check("epp_empty2",  32'(empty), 1);
        // error event coincident with clear: set wins
        drive(0, 1, 1, 8'h00);
        drive(0, 0, 0, 8'h00);
        check("unf_setwins", 32'(underflow), 1);
        drive(0, 0, 1, 8'h00);
        drive(0, 0, 0, 8'h00);
        check("unf_clr2",    32'(underflow), 0);

        // 5: stream 10 entries, pointers start at address 2
        for (int i = 0; i < 12; i++) begin
            drive(i < 10, i >= 2, 0, 8'hD0 + 8'(i));
            if (i < 10) check("strm_waddr", 32'(waddr), 32'((2 + i) % 4));
            if (i >= 2) begin
                check("strm_raddr", 32'(raddr), 32'(i % 4));
                check("strm_rdata", 32'(rdata), 32'hD0 + 32'(i - 2));
            end
        end
        drive(0, 0, 0, 8'h00);
        check("strm_empty",  32'(empty), 1);
        check("strm_count",  32'(count), 0);
        check("strm_unf",    32'(underflow), 0);

        // 6: async reset mid-stream with count 2
        drive(1, 0, 0, 8'hE0);
        drive(1, 0, 0, 8'hE1);
        drive(0, 0, 0, 8'h00);
        check("pre_rst_count", 32'(count), 2);
        check("pre_rst_waddr", 32'(waddr), 2);
        push = 1'b1;
        #1 rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        push = 1'b0;
        @(negedge clk); rst = 1'b0;
        drive(1, 0, 0, 8'hF0);
        check("post_rst_wr_en", 32'(wr_en), 1);
        check("post_rst_waddr", 32'(waddr), 0);
        drive(0, 0, 0, 8'h00);
        check("post_rst_count", 32'(count), 1);
        check("post_rst_rdata", 32'(rdata), 32'hF0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
